// File: rtl/aes_encipher_core.sv
// Iterative AES-128 encryption datapath: one block per start, with one S-box word per cycle
// through an external shared SubWord unit and round keys read from the key generator.
module aes_encipher_core #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         start,
    input  logic [127:0] block_in,
    input  logic         key_ready,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [31:0]  sbox_feed,
    input  logic [31:0]  new_sbox,
    output logic [127:0] block_out,
    output logic         done,
    output logic         busy
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {IDLE, INIT, SUB, MIX} state_t;

    state_t         state, state_nxt;
    logic [127:0]   blk_lat;
    logic [127:0]   st;
    logic [2:0]     wcnt;
    logic [127:0]   mix_res;
    logic           last_round;
    logic           abort;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        return o;
    endfunction

    // Byte (r,c) lives at bits [127-8*(4c+r) -: 8]; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    assign last_round = (round == LAST_ROUND);
    assign abort      = (state != IDLE) && !key_ready;

    always_comb begin
        logic [127:0] sr;
        sr      = shift_rows(st);
        mix_res = (last_round ? sr : mix_columns(sr)) ^ round_key;
    end

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; losing key_ready mid-block abandons the block
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && key_ready) state_nxt = INIT;
            INIT:    state_nxt = SUB;
            SUB:     if (wcnt == 3'd4) state_nxt = MIX;
            MIX:     state_nxt = last_round ? IDLE : SUB;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Output logic
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath and registered outputs
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            round     <= '0;
            sbox_feed <= '0;
            block_out <= '0;
            done      <= 1'b0;
            blk_lat   <= '0;
            st        <= '0;
            wcnt      <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                round <= '0;
                wcnt  <= '0;
            end else begin
                case (state)
                    IDLE: if (start && key_ready) blk_lat <= block_in;
                    INIT: begin
                        st    <= blk_lat ^ round_key;
                        round <= 4'd1;
                        wcnt  <= '0;
                    end
                    SUB: begin
                        // Feed column w while capturing the S-box result of column w-1
                        wcnt <= (wcnt == 3'd4) ? 3'd0 : wcnt + 3'd1;
                        case (wcnt)
                            3'd0: sbox_feed <= st[127:96];
                            3'd1: begin
                                st[127:96] <= new_sbox;
                                sbox_feed  <= st[95:64];
                            end
                            3'd2: begin
                                st[95:64] <= new_sbox;
                                sbox_feed <= st[63:32];
                            end
                            3'd3: begin
                                st[63:32] <= new_sbox;
                                sbox_feed <= st[31:0];
                            end
                            3'd4: st[31:0] <= new_sbox;
                            default: ;
                        endcase
                    end
                    MIX: begin
                        st <= mix_res;
                        if (last_round) begin
                            block_out <= mix_res;
                            done      <= 1'b1;
                            round     <= '0;
                        end else begin
                            round <= round + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_encipher_core.sv
// Directed bench for aes_encipher_core with a behavioural key generator and S-box
// supplying round_key and new_sbox from FIPS-197 definitions.
module tb_aes_encipher_core;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         start;
    logic [127:0] block_in;
    logic         key_ready;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [31:0]  sbox_feed;
    logic [31:0]  new_sbox;
    logic [127:0] block_out;
    logic         done;
    logic         busy;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0]   sbox_tab [0:255];
    logic [127:0] rk [0:15];

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    always #5 aclk = ~aclk;

    aes_encipher_core #(.NUM_ROUNDS(10)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .start     (start),
        .block_in  (block_in),
        .key_ready (key_ready),
        .round     (round),
        .round_key (round_key),
        .sbox_feed (sbox_feed),
        .new_sbox  (new_sbox),
        .block_out (block_out),
        .done      (done),
        .busy      (busy)
    );

    assign round_key = rk[round];
    assign new_sbox  = {sbox_tab[sbox_feed[31:24]], sbox_tab[sbox_feed[23:16]],
                        sbox_tab[sbox_feed[15:8]],  sbox_tab[sbox_feed[7:0]]};

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse (x^254) followed by the FIPS-197 affine transform
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] temp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc   = xt(rc);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 16; r++)
            rk[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Caller raises start with block_in set; the next edge is cycle 0.
    task automatic run(input logic [127:0] pt, input logic [127:0] exp, input bit chk_round,
                       input int pulse_cyc, input bit chain, input string tag);
        int done_cyc;
        int exp_round;
        done_cyc = -1;
        step();
        for (int n = 1; n <= 70; n++) begin
            start = (n == pulse_cyc);
            if (chk_round) begin
                exp_round = (n == 1 || n >= 62) ? 0 : (n - 2) / 6 + 1;
                check($sformatf("%s_round_c%0d", tag, n), 128'(round), 128'(exp_round));
            end
            if (n == 1) check({tag, "_busy_c1"}, 128'(busy), 128'd1);
            if (done) begin
                done_cyc = n;
                break;
            end
            step();
        end
        check({tag, "_done_cycle"}, 128'(done_cyc), 128'd62);
        check({tag, "_block_out"}, block_out, exp);
        check({tag, "_busy_done"}, 128'(busy), 128'd0);
        if (chain) begin
            block_in = pt;
            start    = 1'b1;
        end else begin
            start = 1'b0;
            step();
            check({tag, "_done_single"}, 128'(done), 128'd0);
        end
    endtask

    initial begin
        bit saw_done;
        aresetn   = 1'b0;
        start     = 1'b0;
        block_in  = '0;
        key_ready = 1'b0;
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
        load_key(KEY_B);

        // Reset state
        step(); step();
        check("rst_round", 128'(round), 128'd0);
        check("rst_sbox_feed", 128'(sbox_feed), 128'd0);
        check("rst_block_out", block_out, 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        aresetn = 1'b1;
        step();

        // FIPS-197 Appendix B
        key_ready = 1'b1;
        step();
        block_in = PT_B;
        start    = 1'b1;
        run(PT_B, CT_B, 1'b0, 0, 1'b0, "fips_b");

        // start without key_ready is dropped
        key_ready = 1'b0;
        load_key(KEY_C);
        block_in = PT_C;
        start    = 1'b1;
        step(); step();
        check("nokey_busy", 128'(busy), 128'd0);
        check("nokey_done", 128'(done), 128'd0);
        start     = 1'b0;
        key_ready = 1'b1;
        step(); step(); step();
        check("nokey_late_busy", 128'(busy), 128'd0);
        check("nokey_late_round", 128'(round), 128'd0);
        check("nokey_block_out", block_out, CT_B);

        // FIPS-197 C.1 with round sequence, then back-to-back with a stray start
        block_in = PT_C;
        start    = 1'b1;
        run(PT_C, CT_C, 1'b1, 0, 1'b1, "fips_c1");
        run(PT_C, CT_C, 1'b0, 30, 1'b0, "b2b");

        // key_ready lost at cycle 20 aborts the block
        block_in = PT_B;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 19; i++) step();
        check("abort_busy_before", 128'(busy), 128'd1);
        key_ready = 1'b0;
        step();
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_round", 128'(round), 128'd0);
        check("abort_done", 128'(done), 128'd0);
        check("abort_block_out", block_out, CT_C);
        key_ready = 1'b1;
        saw_done  = 1'b0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", 128'(saw_done), 128'd0);
        check("abort_idle", 128'(busy), 128'd0);

        // Reset at cycle 40, then a clean encryption
        block_in = PT_C;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 39; i++) step();
        check("midrst_busy_before", 128'(busy), 128'd1);
        aresetn = 1'b0;
        step();
        check("midrst_round", 128'(round), 128'd0);
        check("midrst_sbox_feed", 128'(sbox_feed), 128'd0);
        check("midrst_block_out", block_out, 128'd0);
        check("midrst_done", 128'(done), 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        aresetn = 1'b1;
        step();
        block_in = PT_C;
        start    = 1'b1;
        run(PT_C, CT_C, 1'b0, 0, 1'b0, "rst_rerun");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
